timestamp_word_decoder: RTL

// Reader/decoder for the 32-bit timestamp word stream produced by the timestamp capture core.

---
 rtl/tpx3_ts_pkg.sv | 25 ++
 rtl/sat_counter.sv | 25 ++
 rtl/timestamp_word_decoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tpx3_ts_pkg.sv
// rtl/tpx3_ts_pkg.sv - shared constants and types for timestamp word decoding
// Purpose: word field slices, word TYPE codes, timestamp width and decoder state type.
package tpx3_ts_pkg;

    localparam int TS_WIDTH    = 48;
    localparam int PAYLOAD_W   = 24;

    localparam logic [3:0] TS_TYPE_LO  = 4'h1;
    localparam logic [3:0] TS_TYPE_HI  = 4'h2;
    localparam logic [3:0] TS_TYPE_EXT = 4'h3;

    // Word layout: {ID[31:28], TYPE[27:24], PAYLOAD[23:0]}
    localparam int ID_MSB      = 31;
    localparam int ID_LSB      = 28;
    localparam int TYPE_MSB    = 27;
    localparam int TYPE_LSB    = 24;
    localparam int PAYLOAD_MSB = 23;
    localparam int PAYLOAD_LSB = 0;

    typedef enum logic {
        WAIT_LO = 1'b0,
        WAIT_HI = 1'b1
    } ts_dec_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
// Purpose: counts inc_i pulses, holds at all-ones instead of wrapping.
// Ports: clk_i, rst_ni (async active-low), inc_i (count enable), count_o (current value).
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/timestamp_word_decoder.sv
// rtl/timestamp_word_decoder.sv - re-assembles lo/hi timestamp words into 48-bit timestamps
// Purpose: pops 32-bit words from a FIFO, filters on IDENTIFIER, pairs TYPE=1/TYPE=2 words
//          and emits {hi, lo} plus the delta to the previous timestamp on a valid/ready stream.
// Ports: BUS_CLK, BUS_RST_N (async active-low); FIFO_EMPTY/FIFO_READ/FIFO_DATA (source FIFO,
//        data one cycle after the pop); TS_VALID/TS_READY/TS_DATA/TS_DELTA/TS_FIRST (output
//        stream); ERR_CNT/FOREIGN_CNT (saturating sequence-error and foreign-word counters).
module timestamp_word_decoder
    import tpx3_ts_pkg::*;
#(
    parameter logic [3:0] IDENTIFIER = 4'b0001,
    parameter int         CNT_WIDTH  = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic                 FIFO_EMPTY,
    output logic                 FIFO_READ,
    input  logic [31:0]          FIFO_DATA,
    output logic                 TS_VALID,
    input  logic                 TS_READY,
    output logic [TS_WIDTH-1:0]  TS_DATA,
    output logic [TS_WIDTH-1:0]  TS_DELTA,
    output logic                 TS_FIRST,
    output logic [CNT_WIDTH-1:0] ERR_CNT,
    output logic [CNT_WIDTH-1:0] FOREIGN_CNT
);

    ts_dec_state_t          state_q, state_d;
    logic                   rd_pend_q;
    logic [PAYLOAD_W-1:0]   lo_q, lo_d;
    logic [TS_WIDTH-1:0]    prev_q;
    logic                   first_flag_q;
    logic                   ts_valid_q;
    logic [TS_WIDTH-1:0]    ts_data_q;
    logic [TS_WIDTH-1:0]    ts_delta_q;
    logic                   ts_first_q;

    logic                   emit;
    logic                   err_inc;
    logic                   foreign_inc;
    logic                   fifo_read;

    logic [3:0]             word_id;
    logic [3:0]             word_type;
    logic [PAYLOAD_W-1:0]   word_payload;
    logic [TS_WIDTH-1:0]    ts_word;

    assign word_id      = FIFO_DATA[ID_MSB:ID_LSB];
    assign word_type    = FIFO_DATA[TYPE_MSB:TYPE_LSB];
    assign word_payload = FIFO_DATA[PAYLOAD_MSB:PAYLOAD_LSB];
    assign ts_word      = {word_payload, lo_q};

    // A stalled output blocks new reads, so an emit can never land while the
    // previous timestamp is still waiting for TS_READY.
    assign fifo_read = !FIFO_EMPTY && !rd_pend_q && !(ts_valid_q && !TS_READY);

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        emit        = 1'b0;
        err_inc     = 1'b0;
        foreign_inc = 1'b0;
        if (rd_pend_q) begin
            if (word_id != IDENTIFIER) begin
                foreign_inc = 1'b1;
            end else begin
                case (word_type)
                    TS_TYPE_LO: begin
                        // In WAIT_HI the earlier low word lost its partner; the newer one wins.
                        if (state_q == WAIT_HI) begin
                            err_inc = 1'b1;
                        end
                        lo_d    = word_payload;
                        state_d = WAIT_HI;
                    end
                    TS_TYPE_HI: begin
                        if (state_q == WAIT_HI) begin
                            emit    = 1'b1;
                            state_d = WAIT_LO;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                    default: begin
                        err_inc = 1'b1;
                        lo_d    = '0;
                        state_d = WAIT_LO;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q      <= WAIT_LO;
            rd_pend_q    <= 1'b0;
            lo_q         <= '0;
            prev_q       <= '0;
            first_flag_q <= 1'b1;
            ts_valid_q   <= 1'b0;
            ts_data_q    <= '0;
            ts_delta_q   <= '0;
            ts_first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= fifo_read;
            lo_q      <= lo_d;
            if (emit) begin
                ts_valid_q   <= 1'b1;
                ts_data_q    <= ts_word;
                ts_delta_q   <= first_flag_q ? '0 : (ts_word - prev_q);
                ts_first_q   <= first_flag_q;
                prev_q       <= ts_word;
                first_flag_q <= 1'b0;
            end else if (ts_valid_q && TS_READY) begin
                ts_valid_q <= 1'b0;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk_i   (BUS_CLK),
        .rst_ni  (BUS_RST_N),
        .inc_i   (err_inc),
        .count_o (ERR_CNT)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_foreign_cnt (
        .clk_i   (BUS_CLK),
        .rst_ni  (BUS_RST_N),
        .inc_i   (foreign_inc),
        .count_o (FOREIGN_CNT)
    );

    assign FIFO_READ = fifo_read;
    assign TS_VALID  = ts_valid_q;
    assign TS_DATA   = ts_data_q;
    assign TS_DELTA  = ts_delta_q;
    assign TS_FIRST  = ts_first_q;

endmodule
